// File: rtl/writeback_queue.sv
// writeback_queue: circular FIFO of pending register writes with read forwarding of the youngest match
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       InValid,
    input  logic [4:0]                 InRegister,
    input  logic [31:0]                InData,
    output logic                       InReady,
    input  logic                       Hold,
    output logic [4:0]                 WriteRegister,
    output logic [31:0]                WriteData,
    output logic                       RegWrite,
    input  logic [4:0]                 ReadRegister1,
    input  logic [4:0]                 ReadRegister2,
    input  logic [31:0]                RegFileData1,
    input  logic [31:0]                RegFileData2,
    output logic [31:0]                ReadData1,
    output logic [31:0]                ReadData2,
    output logic [$clog2(DEPTH):0]     Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    reg_q [DEPTH];
    logic [4:0]    reg_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic          accept, drain, busy;
    assign busy          = count_q != '0;
    assign InReady       = count_q < CW'(DEPTH);
    assign RegWrite      = busy && !Hold;
    assign drain         = RegWrite;
    assign accept        = InValid && InReady && (InRegister != 5'd0);
    assign WriteRegister = busy ? reg_q[head_q] : 5'd0;
    assign WriteData     = busy ? data_q[head_q] : 32'd0;
    assign Count         = count_q;
    function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] rf);
        logic [31:0]   v;
        logic [AW-1:0] idx;
        v = rf;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (ra != 5'd0 && CW'(i) < count_q && reg_q[idx] == ra) v = data_q[idx];
        end
        return v;
    endfunction
    always_comb begin
        head_d  = drain ? head_q + 1'b1 : head_q;
        tail_d  = accept ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(accept) - CW'(drain);
        reg_d   = reg_q;
        data_d  = data_q;
        if (accept) begin
            reg_d[tail_q]  = InRegister;
            data_d[tail_q] = InData;
        end
    end
    always_comb begin
        ReadData1 = fwd(ReadRegister1, RegFileData1);
        ReadData2 = fwd(ReadRegister2, RegFileData2);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        reg_q  <= reg_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: queue-based reference model checked every cycle, plus directed literal scenarios
module tb_writeback_queue;
    localparam int DEPTH = 4;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1, InValid = 1'b0, Hold = 1'b0;
    logic [4:0]  InRegister = '0, ReadRegister1 = '0, ReadRegister2 = '0;
    logic [31:0] InData = '0, RegFileData1 = '0, RegFileData2 = '0;
    logic        InReady, RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData, ReadData1, ReadData2;
    logic [$clog2(DEPTH):0] Count;
    int passed = 0, total = 0;
    bit live = 1'b0;
    typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
    ent_t mq[$];

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InRegister(InRegister), .InData(InData),
        .InReady(InReady), .Hold(Hold), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .RegWrite(RegWrite), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RegFileData1(RegFileData1), .RegFileData2(RegFileData2), .ReadData1(ReadData1),
        .ReadData2(ReadData2), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] rf);
        logic [31:0] v = rf;
        if (ra != 5'd0) foreach (mq[i]) if (mq[i].r == ra) v = mq[i].d;
        return v;
    endfunction

    task automatic model_edge();
        bit dr, ac;
        if (Reset) begin
            mq.delete();
            return;
        end
        dr = mq.size() != 0 && !Hold;
        ac = InValid && mq.size() < DEPTH && InRegister != 5'd0;
        if (dr) void'(mq.pop_front());
        if (ac) mq.push_back('{r: InRegister, d: InData});
    endtask

    always @(posedge Clk) begin
        model_edge();
        live <= 1'b1;
    end

    always @(negedge Clk) if (live) begin
        chk("m_count", 32'(Count), mq.size());
        chk("m_inready", 32'(InReady), 32'(mq.size() < DEPTH));
        chk("m_regwrite", 32'(RegWrite), 32'(mq.size() != 0 && !Hold));
        chk("m_wreg", 32'(WriteRegister), mq.size() != 0 ? 32'(mq[0].r) : 32'd0);
        chk("m_wdata", WriteData, mq.size() != 0 ? mq[0].d : 32'd0);
        chk("m_rd1", ReadData1, fwd(ReadRegister1, RegFileData1));
        chk("m_rd2", ReadData2, fwd(ReadRegister2, RegFileData2));
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        step();
        Reset = 1'b0;
        RegFileData1 = 32'h1234;
        ReadRegister1 = 5'd3;
        @(negedge Clk);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_inready", 32'(InReady), 32'd1);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_rd1", ReadData1, 32'h1234);
        // single write
        step();
        InValid = 1'b1; InRegister = 5'd11; InData = 32'h45;
        step();
        InValid = 1'b0;
        @(negedge Clk);
        chk("single_regwrite", 32'(RegWrite), 32'd1);
        chk("single_wreg", 32'(WriteRegister), 32'd11);
        chk("single_wdata", WriteData, 32'h45);
        step();
        @(negedge Clk);
        chk("single_count", 32'(Count), 32'd0);
        // forwarding returns the youngest of two pending writes
        step();
        Hold = 1'b1; InValid = 1'b1; InRegister = 5'd21; InData = 32'h15;
        step();
        InData = 32'h2A;
        step();
        InValid = 1'b0; ReadRegister1 = 5'd21; RegFileData1 = 32'd0;
        @(negedge Clk);
        chk("fwd_rd1", ReadData1, 32'h2A);
        chk("fwd_regwrite", 32'(RegWrite), 32'd0);
        step();
        Hold = 1'b0;
        @(negedge Clk);
        chk("fwd_drain0", WriteData, 32'h15);
        step();
        @(negedge Clk);
        chk("fwd_drain1", WriteData, 32'h2A);
        chk("fwd_head_rd1", ReadData1, 32'h2A);
        step();
        @(negedge Clk);
        chk("fwd_empty_rd1", ReadData1, 32'd0);
        // fill to full, fifth offer refused
        Hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            InValid = 1'b1; InRegister = 5'(i); InData = 32'(i * 16);
            step();
        end
        InRegister = 5'd5; InData = 32'h50;
        @(negedge Clk);
        chk("full_count", 32'(Count), 32'd4);
        chk("full_inready", 32'(InReady), 32'd0);
        step();
        @(negedge Clk);
        chk("full_count_after", 32'(Count), 32'd4);
        step();
        InValid = 1'b0; Hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            chk("full_drain_reg", 32'(WriteRegister), 32'(i));
            step();
        end
        @(negedge Clk);
        chk("full_drained", 32'(Count), 32'd0);
        // simultaneous accept and drain, wrapping the pointers
        Hold = 1'b1; InValid = 1'b1; InRegister = 5'd2; InData = 32'h22;
        step();
        InRegister = 5'd3; InData = 32'h33;
        step();
        Hold = 1'b0; InRegister = 5'd7; InData = 32'h77;
        @(negedge Clk);
        chk("sim_count_pre", 32'(Count), 32'd2);
        chk("sim_regwrite", 32'(RegWrite), 32'd1);
        step();
        for (int k = 0; k < 10; k++) begin
            InRegister = 5'(8 + k); InData = 32'(k);
            @(negedge Clk);
            chk("sim_count", 32'(Count), 32'd2);
            step();
        end
        InValid = 1'b0;
        step();
        step();
        @(negedge Clk);
        chk("sim_empty", 32'(Count), 32'd0);
        // register 0 writes are swallowed
        InValid = 1'b1; InRegister = 5'd0; InData = 32'hFFFFFFFF;
        ReadRegister2 = 5'd0; RegFileData2 = 32'hCAFE;
        step();
        InValid = 1'b0;
        @(negedge Clk);
        chk("r0_count", 32'(Count), 32'd0);
        chk("r0_regwrite", 32'(RegWrite), 32'd0);
        chk("r0_rd2", ReadData2, 32'hCAFE);
        // reset mid-operation
        Hold = 1'b1; InValid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            InRegister = 5'(i); InData = 32'(i);
            step();
        end
        InValid = 1'b0;
        @(negedge Clk);
        chk("rst_mid_count_pre", 32'(Count), 32'd3);
        Reset = 1'b1;
        step();
        Reset = 1'b0; Hold = 1'b0;
        @(negedge Clk);
        chk("rst_mid_count", 32'(Count), 32'd0);
        chk("rst_mid_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_mid_inready", 32'(InReady), 32'd1);
        InValid = 1'b1; InRegister = 5'd9; InData = 32'h99;
        step();
        InValid = 1'b0;
        @(negedge Clk);
        chk("rst_mid_wreg", 32'(WriteRegister), 32'd9);
        chk("rst_mid_wdata", WriteData, 32'h99);
        // randomized traffic, alternating light and heavy Hold phases
        for (int c = 0; c < 600; c++) begin
            step();
            Reset = $urandom_range(0, 63) == 0;
            InValid = $urandom_range(0, 3) != 0;
            InRegister = $urandom_range(0, 7) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            InData = $urandom;
            Hold = $urandom_range(0, 99) < (((c / 100) % 2) != 0 ? 70 : 20);
            ReadRegister1 = 5'($urandom_range(0, 7));
            ReadRegister2 = 5'($urandom_range(0, 7));
            RegFileData1 = $urandom;
            RegFileData2 = $urandom;
        end
        step();
        @(negedge Clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
